// File: rtl/qam_mod_core_if.sv
// rtl/qam_mod_core_if.sv - symbol-in / passband-sample-out bundle for qam_mod_core
interface qam_mod_core_if #(
    parameter int PHASE_W = 16,
    parameter int DATA_W  = 12
);
    logic [1:0]               mode;
    logic [PHASE_W-1:0]       fcw;
    logic                     din_valid;
    logic [5:0]               din;
    logic                     din_ready;
    logic                     qam_valid;
    logic signed [DATA_W-1:0] qam_out;
    logic                     sym_start;

    modport master (
        output mode, fcw, din_valid, din,
        input  din_ready, qam_valid, qam_out, sym_start
    );

    modport slave (
        input  mode, fcw, din_valid, din,
        output din_ready, qam_valid, qam_out, sym_start
    );
endinterface

// File: rtl/qam_mod_core.sv
// rtl/qam_mod_core.sv - QPSK/16/64-QAM Gray mapper with NCO upconversion; QAM_PHASE_SYNC_EN zeroes phase at burst start
module qam_mod_core #(
    parameter int CAR_W   = 8,
    parameter int LUT_AW  = 6,
    parameter int PHASE_W = 16,
    parameter int SPS     = 16,
    parameter int DATA_W  = 12
) (
    input  logic          axi_clk,
    input  logic          axi_rst,
    qam_mod_core_if.slave bus
);
    localparam int LUT_DEPTH = 1 << LUT_AW;
    localparam int PROD_W    = CAR_W + 4;
    localparam int DIFF_W    = PROD_W + 1;
    localparam int CNT_W     = $clog2(SPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

    if (DATA_W < CAR_W + 4) begin : g_bad_data_w
        $error("DATA_W must be at least CAR_W+4");
    end
    if (PHASE_W <= LUT_AW) begin : g_bad_phase_w
        $error("PHASE_W must exceed LUT_AW");
    end
    if (SPS < 2) begin : g_bad_sps
        $error("SPS must be at least 2");
    end

    // Table contents are elaboration constants; the series avoids relying on $sin support in synthesis.
    function automatic logic signed [CAR_W-1:0] lut_entry(input int k, input logic want_cos);
        real x, term, acc, amp, v;
        int  r;
        x = 6.283185307179586 * $itor(k) / $itor(LUT_DEPTH);
        if (x > 3.141592653589793) x = x - 6.283185307179586;
        amp  = $itor((1 << (CAR_W - 1)) - 1);
        term = want_cos ? 1.0 : x;
        acc  = term;
        for (int n = 1; n < 16; n++) begin
            if (want_cos) term = -term * x * x / $itor((2 * n - 1) * (2 * n));
            else          term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            acc = acc + term;
        end
        v = amp * acc;
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return r[CAR_W-1:0];
    endfunction

    function automatic logic signed [3:0] level_qpsk(input logic g);
        return {~g, ~g, ~g, 1'b1};
    endfunction

    function automatic logic signed [3:0] level_16(input logic [1:0] g);
        return {~g[1], ~g[1], g[1] ^ g[0], 1'b1};
    endfunction

    // Gray-decode to binary b, then level = 2b - 7 written as an MSB flip.
    function automatic logic signed [3:0] level_64(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = g[2] ^ g[1] ^ g[0];
        return {~b[2], b[1], b[0], 1'b1};
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         cnt, cnt_next;
    logic                     ready_c;
    logic                     accept, burst_start;
    logic [PHASE_W-1:0]       phase, phase_eff;
    logic [LUT_AW-1:0]        lut_addr;
    logic signed [CAR_W-1:0]  sin_tab [LUT_DEPTH];
    logic signed [CAR_W-1:0]  cos_tab [LUT_DEPTH];
    logic signed [CAR_W-1:0]  sin_r, cos_r;
    logic signed [3:0]        lvl_i, lvl_q, i_r, q_r;
    logic signed [PROD_W-1:0] prod_i, prod_q;
    logic signed [DIFF_W-1:0] diff;
    logic                     valid_r, start_r;
    logic signed [DATA_W-1:0] out_r;

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        assign sin_tab[k] = lut_entry(k, 1'b0);
        assign cos_tab[k] = lut_entry(k, 1'b1);
    end

    always_comb begin
        lvl_i = '0;
        lvl_q = '0;
        case (bus.mode)
            2'b00: begin
                lvl_i = level_qpsk(bus.din[1]);
                lvl_q = level_qpsk(bus.din[0]);
            end
            2'b10: begin
                lvl_i = level_64(bus.din[5:3]);
                lvl_q = level_64(bus.din[2:0]);
            end
            default: begin
                lvl_i = level_16(bus.din[3:2]);
                lvl_q = level_16(bus.din[1:0]);
            end
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready_c    = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.din_valid) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    ready_c  = 1'b1;
                    cnt_next = '0;
                    if (!bus.din_valid) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept      = bus.din_valid & ready_c;
    assign burst_start = accept & (state == IDLE);

`ifdef QAM_PHASE_SYNC_EN
    assign phase_eff = burst_start ? '0 : phase;
`else
    assign phase_eff = phase;
`endif

    assign lut_addr = phase_eff[PHASE_W-1 -: LUT_AW];

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state <= IDLE;
            cnt   <= '0;
            phase <= '0;
            sin_r <= '0;
            cos_r <= '0;
            i_r   <= '0;
            q_r   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            phase <= phase_eff + bus.fcw;
            sin_r <= sin_tab[lut_addr];
            cos_r <= cos_tab[lut_addr];
            if (accept) begin
                i_r <= lvl_i;
                q_r <= lvl_q;
            end
        end
    end

    assign prod_i = PROD_W'(i_r) * PROD_W'(cos_r);
    assign prod_q = PROD_W'(q_r) * PROD_W'(sin_r);
    assign diff   = DIFF_W'(prod_i) - DIFF_W'(prod_q);

    // RUN state doubles as the stage-1 valid: its cycles line up with the registered symbol samples.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            valid_r <= 1'b0;
            start_r <= 1'b0;
            out_r   <= '0;
        end else begin
            valid_r <= (state == RUN);
            start_r <= (state == RUN) && (cnt == '0);
            out_r   <= (state == RUN) ? DATA_W'(diff) : '0;
        end
    end

    assign bus.din_ready = ready_c;
    assign bus.qam_valid = valid_r;
    assign bus.sym_start = start_r;
    assign bus.qam_out   = out_r;
endmodule

// File: tb/tb_qam_mod_core.sv
// tb/tb_qam_mod_core.sv - scoreboard bench for qam_mod_core
module tb_qam_mod_core;
    localparam int CAR_W   = 8;
    localparam int LUT_AW  = 6;
    localparam int PHASE_W = 16;
    localparam int SPS     = 16;
    localparam int DATA_W  = 12;
`ifdef QAM_PHASE_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    typedef struct {
        int out;
        bit start;
    } exp_t;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   sin_t [64];
    int   cos_t [64];
    exp_t exp_q [$];
    int   busy;
    logic [PHASE_W-1:0] ph;
    int   run_len = 0;
    int   max_run = 0;
    int   start_cnt = 0;

    qam_mod_core_if #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) bus ();

    qam_mod_core #(
        .CAR_W(CAR_W), .LUT_AW(LUT_AW), .PHASE_W(PHASE_W), .SPS(SPS), .DATA_W(DATA_W)
    ) dut (
        .axi_clk(clk),
        .axi_rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wire model_ready = (busy <= 1);
    wire accept_m    = bus.din_valid && model_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 0;
            ph   <= '0;
        end else begin
            ph   <= ((SYNC && accept_m && busy == 0) ? '0 : ph) + bus.fcw;
            busy <= accept_m ? SPS : ((busy > 0) ? busy - 1 : 0);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int lvl(input int m, input int d, input bit is_i);
        int t16 [4];
        int t64 [8];
        int g;
        t16 = '{-3, -1, 3, 1};
        t64 = '{-7, -5, -1, -3, 7, 5, 1, 3};
        case (m)
            0: begin
                g = is_i ? ((d >> 1) & 1) : (d & 1);
                return (g == 1) ? 1 : -1;
            end
            2: begin
                g = is_i ? ((d >> 3) & 7) : (d & 7);
                return t64[g];
            end
            default: begin
                g = is_i ? ((d >> 2) & 3) : (d & 3);
                return t16[g];
            end
        endcase
    endfunction

    task automatic push_symbol(input int m, input int d);
        int li, lq, idx;
        logic [PHASE_W-1:0] p;
        exp_t e;
        li = lvl(m, d, 1'b1);
        lq = lvl(m, d, 1'b0);
        p  = (SYNC && busy == 0) ? '0 : ph;
        for (int k = 0; k < SPS; k++) begin
            idx     = int'(p >> (PHASE_W - LUT_AW));
            e.out   = li * cos_t[idx] - lq * sin_t[idx];
            e.start = (k == 0);
            exp_q.push_back(e);
            p = p + bus.fcw;
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [5:0] d);
        int n = 0;
        bus.mode      = m;
        bus.din       = d;
        bus.din_valid = 1'b1;
        @(negedge clk);
        while (!model_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("accept_timeout", n, 0);
        else push_symbol(int'(m), int'(d));
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("din_ready", bus.din_ready, model_ready);
            if (bus.qam_valid === 1'b1) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (bus.sym_start === 1'b1) start_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", bus.qam_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("qam_out", bus.qam_out, e.out);
                    check("sym_start", bus.sym_start, e.start);
                end
            end else begin
                run_len = 0;
                check("idle_valid", bus.qam_valid, 0);
                check("idle_out", bus.qam_out, 0);
                check("idle_start", bus.sym_start, 0);
            end
        end
    end

    initial begin
        real a;
        for (int k = 0; k < 64; k++) begin
            a = 6.283185307179586 * k / 64.0;
            a = 127.0 * $sin(a);
            sin_t[k] = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
            a = 127.0 * $cos(6.283185307179586 * k / 64.0);
            cos_t[k] = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
        end
        rst           = 1'b1;
        bus.mode      = 2'b00;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.fcw       = '0;
        #1;
        check("rst_din_ready", bus.din_ready, 1);
        check("rst_qam_valid", bus.qam_valid, 0);
        check("rst_qam_out", bus.qam_out, 0);
        check("rst_sym_start", bus.sym_start, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // phase is still 0 after reset with fcw=0, so index 0 is known in either build
        send(2'b01, 6'b000000);
        @(negedge clk);
        check("lat_n1_valid", bus.qam_valid, 0);
        @(negedge clk);
        check("qam16_first", bus.qam_out, -381);
        check("qam16_first_start", bus.sym_start, 1);
        repeat (16) @(negedge clk);
        check("underflow_valid", bus.qam_valid, 0);

        apply_reset();
        repeat (3) @(posedge clk);
        #1 bus.fcw = 16'd1024;
        send(2'b10, 6'b100100);
        repeat (2) @(negedge clk);
        check("qam64_first", bus.qam_out, 889);
        check("qam64_first_start", bus.sym_start, 1);
        repeat (4) @(negedge clk);
        check("qam64_idx4", bus.qam_out, 476);
        repeat (16) @(posedge clk);
        #1;

        bus.fcw   = 16'd1536;
        max_run   = 0;
        start_cnt = 0;
        for (int i = 0; i < 8; i++) send(2'b00, 6'(i));
        repeat (24) @(posedge clk);
        #1;
        check("b2b_run_len", max_run, 128);
        check("b2b_sym_starts", start_cnt, 8);

        bus.fcw = 16'd777;
        send(2'b01, 6'b001101);
        repeat (5) @(posedge clk);
        #1 bus.mode = 2'b10;
        send(2'b10, 6'b011110);
        send(2'b11, 6'b000110);
        repeat (24) @(posedge clk);
        #1;

        bus.fcw = 16'($urandom);
        for (int i = 0; i < 6; i++) send(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
        repeat (24) @(posedge clk);
        #1;

        bus.fcw = 16'd2048;
        send(2'b10, 6'b010111);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_valid", bus.qam_valid, 0);
        check("midrst_out", bus.qam_out, 0);
        check("midrst_ready", bus.din_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(2'b01, 6'b001011);
        @(negedge clk);
        check("postrst_n1_valid", bus.qam_valid, 0);
        @(negedge clk);
        check("postrst_n2_valid", bus.qam_valid, 1);
        check("postrst_n2_start", bus.sym_start, 1);
        repeat (24) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/qam_mod_core.md
Name: qam_mod_core

Overview:
Parametrised multi-order QAM modulator and successor to the fixed 16-QAM datapath. It accepts symbols over a valid/ready handshake and Gray-maps them to I/Q levels for QPSK, 16-QAM or 64-QAM, selected at run time. Each symbol is held for SPS samples. A phase-accumulator NCO with a sin/cos LUT generates the carrier, and the block emits the real passband sample I·cos − Q·sin. It sits between the framing logic and the DAC interface.

Parameters:
CAR_W, 8, signed carrier amplitude width; LUT amplitude A = 2^(CAR_W-1)-1.
LUT_AW, 6, LUT address width; LUT_DEPTH = 2^LUT_AW samples per carrier period.
PHASE_W, 16, phase accumulator width; must satisfy PHASE_W > LUT_AW.
SPS, 16, output samples per symbol; must be ≥ 2.
DATA_W, 12, output width; must be ≥ CAR_W+4, checked at elaboration.

Ports:
axi_clk  in  1  clock.
axi_rst  in  1  reset.
mode  in  2  modulation order: 00 QPSK, 01 16-QAM, 10 64-QAM, 11 reserved (treated as 16-QAM).
fcw  in  PHASE_W  carrier frequency control word, added to the phase every cycle.
din_valid  in  1  symbol valid.
din  in  6  symbol bits, LSB-aligned: QPSK uses [1:0], 16-QAM [3:0], 64-QAM [5:0].
din_ready  out  1  block can accept a symbol this cycle.
qam_valid  out  1  qam_out carries a modulated sample.
qam_out  out  DATA_W  signed passband sample, I·cos − Q·sin.
sym_start  out  1  pulses with the first sample of each symbol, aligned with qam_valid.

Behaviour:
- Clocking and reset: one clock, axi_clk. Reset axi_rst is asynchronous and active-high.
- Reset values: all outputs 0 except din_ready, which is 1. Phase accumulator 0, sample counter 0, state IDLE.
- Phase: the accumulator adds fcw every cycle, wraps modulo 2^PHASE_W and runs continuously, including during idle.
- LUT: addressed by phase[PHASE_W-1 -: LUT_AW]. Entry k holds sin = round(A·sin(2πk/LUT_DEPTH)) and cos = round(A·cos(2πk/LUT_DEPTH)).
- Gray mapping per axis; I takes the upper half of the used bits, Q the lower half.
  - QPSK: 0→−1, 1→+1.
  - 16-QAM: 00→−3, 01→−1, 11→+1, 10→+3.
  - 64-QAM: 000→−7, 001→−5, 011→−3, 010→−1, 110→+1, 111→+3, 101→+5, 100→+7.
- Level format: 4-bit signed.
- Arithmetic: products are full precision; the difference is sign-extended to DATA_W. No rounding or saturation is needed.
- FSM states:
  - IDLE: din_ready=1. On din_valid, latch I/Q and mode, go to RUN, counter=0.
  - RUN: counter increments each cycle.
    - din_ready=1 only when counter==SPS-1.
    - At SPS-1 with din_valid: latch the next symbol, counter=0, stay in RUN. This gives gapless back-to-back symbols.
    - At SPS-1 without din_valid: go to IDLE (underflow).
- Mode is sampled only at symbol acceptance; a mid-symbol change affects the next symbol only.
- Pipeline latency: a handshake in cycle N gives its first output sample in cycle N+2.
  - Stage 1 registers I/Q and the LUT read.
  - Stage 2 registers the multiply/subtract, qam_valid and sym_start.
- Timing per symbol: qam_valid is high for exactly SPS consecutive cycles. sym_start pulses on the first of them.
- Underflow: after the last sample of a symbol with no new input, qam_valid=0 and qam_out=0 until the next accepted symbol.
- Reset mid-symbol: outputs and pipeline clear immediately; the in-flight symbol is discarded and not replayed.

Optional Feature:
QAM_PHASE_SYNC_EN:
- Defined: a symbol accepted from IDLE (burst start) forces the phase accumulator to 0 in the accept cycle. The first sample of every burst therefore uses LUT index 0 (cos=A, sin=0).
- Undefined: the accumulator is free-running and burst-start phase is arbitrary.
- Back-to-back symbols never reset the phase in either case.

Test Plan:
- Reset release with din_valid=0, fcw=0 → din_ready=1, qam_valid=0, qam_out=0 indefinitely.
- QAM_PHASE_SYNC_EN, mode=01, din=4'b0000, fcw=1024 → I=Q=−3; first sample (cycle N+2) = −381 with sym_start=1; 16 valid samples, then qam_valid=0.
- QAM_PHASE_SYNC_EN, mode=10, din=6'b100100 → I=Q=+7; first sample = 889; 4 cycles later (LUT index 4) = 7·(cos−sin) per LUT.
- Continuous din_valid, mode=00, 8 symbols → din_ready pulses once every 16 cycles; qam_valid high for 128 consecutive cycles; 8 sym_start pulses spaced 16 apart.
- Mode changed 01→10 mid-symbol → current symbol keeps 16-QAM levels; the next accepted symbol uses 64-QAM mapping.
- axi_rst asserted at counter=7 of a symbol → same cycle: qam_valid=0, qam_out=0, din_ready=1; after release the next symbol is accepted normally with latency 2.
